load_store_unit: RTL and testbench
==================================

# load_store_unit

Multi-cycle data-memory access stage for the RISC-V core, sitting directly downstream of the register-file/ALU datapath. It takes the ALU result as the effective address and the rs2 read value as store data. It drives a simple request/ready data bus with byte enables and returns the aligned, sign- or zero-extended load value to the writeback mux. While an access is in flight it holds the core with a stall signal.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16, number of ACCESS cycles without bus_ready before an access is aborted (used only with LSU_TIMEOUT_EN).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- mem_rd  in  1  current instruction is a load.
- mem_wr  in  1  current instruction is a store; wins if both are high.
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are loads only).
- addr  in  32  effective address (ALU result).
- wdata  in  32  store data (rs2 value).
- rdata  out  32  extended load result to writeback.
- stall  out  1  hold PC and suppress register write.
- misalign  out  1  one-cycle pulse on a misaligned request.
- fault  out  1  one-cycle pulse on bus timeout.
- bus_req  out  1  bus request.
- bus_we  out  1  1 = write.
- bus_addr  out  32  word address, with bits [1:0] = 00.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_ready  in  1  access complete this cycle.
- bus_rdata  in  32  read word, valid when bus_ready = 1.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE, with mem_rd or mem_wr high and the address aligned:
  - latch funct3, addr[1:0], we, word address, bus_be and bus_wdata;
  - go to ACCESS.
- IDLE, with mem_rd or mem_wr high and the address misaligned (H with addr[0] = 1, W with addr[1:0] ≠ 00):
  - misalign = 1 for that cycle;
  - stall = 0; no bus transaction; stay in IDLE.
- ACCESS:
  - bus_req = 1; all bus outputs held stable;
  - on bus_ready = 1, capture the extended load result into rdata (stores leave rdata = 0) and go to DONE.
- DONE:
  - stall = 0 and rdata is valid; the core commits at the end of this cycle;
  - always go to IDLE, never re-launch, even though mem_rd/mem_wr are still high for the same instruction.
- stall = (IDLE and request and aligned) or ACCESS.
- Byte enables:
  - B: 0001 << addr[1:0];
  - H: 0011 if addr[1] = 0, otherwise 1100;
  - W: 1111.
- Store data lanes: B replicates wdata[7:0] ×4; H replicates wdata[15:0] ×2; W passes wdata through.
- Load extraction: select the byte or half from bus_rdata by addr[1:0]. B/H sign-extend; BU/HU zero-extend.
- Reserved funct3 values are treated as W.

## Timing
- Reset (rst_n = 0 at an edge):
  - state = IDLE; rdata, misalign, fault, bus_req, bus_we, bus_addr, bus_be and bus_wdata all become 0;
  - stall = 0 after the edge. While rst_n is low, the combinational stall term is forced to 0.
- Reset mid-access drops bus_req on the same edge. Any late bus_ready is ignored.
- Minimum latency is 3 cycles: accept (IDLE, stall = 1), ACCESS with bus_ready the same cycle, DONE (stall = 0). Each extra wait cycle adds one ACCESS cycle.
- bus_req is registered and stays high until the cycle bus_ready is sampled high.
- rdata holds its value until the next accepted access.

## Configuration
- LSU_TIMEOUT_EN defined:
  - a counter clears on entry to ACCESS and increments each ACCESS cycle without bus_ready;
  - on reaching TIMEOUT_CYCLES, bus_req drops and the FSM goes to DONE with rdata = 0 and fault = 1 for the DONE cycle;
  - bus_ready in the same cycle the count is reached wins (normal completion).
- LSU_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely; fault is tied to 0.

## Structure
- Shared package riscv_pkg:
  - funct3 size constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - LSU state encoding.
- One combinational sub-module, lsu_align: byte-enable generation, store lane replication, load extraction/extension and misalign detection.
- FSM and timeout counter stay in load_store_unit.

## Test plan
- SW addr 0x100, wdata 0xDEADBEEF, bus_ready on the first ACCESS cycle -> bus_addr 0x100, be 1111, we 1, stall high 2 cycles, DONE in cycle 3.
- LB addr 0x103, bus_rdata 0x80FF_0000, 2 wait cycles -> be 1000, stall 4 cycles, rdata 0xFFFFFF80; LBU at the same address -> 0x00000080.
- SH addr 0x202, wdata 0x1234ABCD -> be 1100, bus_wdata 0xABCDABCD; LW addr 0x202 -> misalign pulse, no bus_req, stall 0.
- rst_n low in the second ACCESS cycle of a load -> next cycle bus_req 0, state IDLE, rdata 0; a bus_ready arriving afterwards has no effect.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES 4, bus_ready never asserted -> bus_req high 4 cycles, then DONE with fault = 1, rdata 0, stall 0.
- mem_rd and mem_wr both high, funct3 W, addr 0x10 -> store issued (bus_we 1).

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared funct3 access-size codes and load/store unit state encoding
package riscv_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} lsu_state_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte enables, store lane replication, load extraction and misalign detection
// Request side: funct3/off/wdata -> be, lanes, misalign.
// Response side: ld_funct3/ld_off/bus_rdata -> ld_data (sign- or zero-extended).
// Reserved funct3 codes fall through to word behaviour.
import riscv_pkg::*;
module lsu_align (
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] lanes,
  output logic        misalign,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] bus_rdata,
  output logic [31:0] ld_data
);
  logic        is_b, is_h, ld_b, ld_h;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  assign is_b     = funct3 == F3_B || funct3 == F3_BU;
  assign is_h     = funct3 == F3_H || funct3 == F3_HU;
  assign ld_b     = ld_funct3 == F3_B || ld_funct3 == F3_BU;
  assign ld_h     = ld_funct3 == F3_H || ld_funct3 == F3_HU;
  assign be       = is_b ? 4'b0001 << off : is_h ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign lanes    = is_b ? {4{wdata[7:0]}} : is_h ? {2{wdata[15:0]}} : wdata;
  assign misalign = is_h ? off[0] : !is_b && off != 2'b00;
  assign byte_v   = bus_rdata[{ld_off, 3'b000} +: 8];
  assign half_v   = ld_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
  // funct3[2] marks the unsigned variants, so it suppresses the sign bit
  assign ld_data  = ld_b ? {{24{byte_v[7] & ~ld_funct3[2]}}, byte_v}
                  : ld_h ? {{16{half_v[15] & ~ld_funct3[2]}}, half_v}
                  : bus_rdata;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle data-memory access stage with request/ready bus and core stall
// Core side: mem_rd/mem_wr (store wins), funct3, addr, wdata in; rdata, stall, misalign, fault out.
// Bus side: bus_req, bus_we, bus_addr (word aligned), bus_be, bus_wdata out; bus_ready, bus_rdata in.
// Optional LSU_TIMEOUT_EN: abort an access after TIMEOUT_CYCLES unanswered ACCESS cycles.
import riscv_pkg::*;
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misalign,
  output logic        fault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);
  lsu_state_t  state;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [3:0]  be;
  logic [31:0] lanes, ld_data;
  logic        mis, req, accept, timeout;
  lsu_align u_align (
    .funct3(funct3), .off(addr[1:0]), .wdata(wdata), .be(be), .lanes(lanes), .misalign(mis),
    .ld_funct3(f3_q), .ld_off(off_q), .bus_rdata(bus_rdata), .ld_data(ld_data)
  );
  assign req      = mem_rd || mem_wr;
  assign accept   = rst_n && state == IDLE && req && !mis;
  assign stall    = accept || (rst_n && state == ACCESS);
  assign misalign = rst_n && state == IDLE && req && mis;
`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TLIM = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt;
  // bus_ready in the final counted cycle still completes normally
  assign timeout = state == ACCESS && !bus_ready && cnt == TLIM;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      fault <= 1'b0;
    end else begin
      cnt   <= state == ACCESS ? cnt + 1'b1 : '0;
      fault <= timeout;
    end
  end
`else
  logic [31:0] unused_tmo;
  assign unused_tmo = TIMEOUT_CYCLES;
  assign timeout    = 1'b0;
  assign fault      = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rdata     <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      f3_q      <= F3_W;
      off_q     <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state     <= ACCESS;
          bus_req   <= 1'b1;
          bus_we    <= mem_wr;
          bus_addr  <= {addr[31:2], 2'b00};
          bus_be    <= be;
          bus_wdata <= lanes;
          f3_q      <= funct3;
          off_q     <= addr[1:0];
        end
        ACCESS: if (bus_ready || timeout) begin
          state   <= DONE;
          bus_req <= 1'b0;
          rdata   <= bus_ready && !bus_we ? ld_data : '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed transactions checked every cycle against a transaction-level model
module tb_load_store_unit;
  localparam int TMO = 4;
  logic clk = 0, rst_n;
  logic mem_rd, mem_wr, bus_ready;
  logic [2:0] funct3;
  logic [31:0] addr, wdata, bus_rdata;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [3:0] bus_be;
  logic stall, misalign, fault, bus_req, bus_we;
  int total = 0, passed = 0;
  logic chk_en = 0;
  logic e_stall, e_req, e_mis, e_fault, e_bus, e_chk_rd, e_we;
  logic [31:0] e_addr, e_wd, e_rdata;
  logic [3:0] e_be;
  int n_st, n_req;
  logic saw_mis, seen_req, seen_we, seen_fault;
  logic [31:0] seen_addr, seen_wd, seen_rd;
  logic [3:0] seen_be;

  load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .mem_rd(mem_rd), .mem_wr(mem_wr), .funct3(funct3), .addr(addr),
    .wdata(wdata), .rdata(rdata), .stall(stall), .misalign(misalign), .fault(fault),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, required %h", n, act, exp);
    else passed++;
  endtask

  function automatic int m_size(input logic [2:0] f3);
    return (f3 == 3'b000 || f3 == 3'b100) ? 1 : (f3 == 3'b001 || f3 == 3'b101) ? 2 : 4;
  endfunction

  function automatic logic m_mis(input logic [2:0] f3, input logic [31:0] a);
    return (a % m_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] ones = 4'((1 << m_size(f3)) - 1);
    return ones << a[1:0];
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] d);
    int n = m_size(f3);
    return n == 1 ? {4{d[7:0]}} : n == 2 ? {2{d[15:0]}} : d;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] v = w >> (8 * a[1:0]);
    case (f3)
      3'b000:  return {{24{v[7]}}, v[7:0]};
      3'b100:  return v & 32'h0000_00FF;
      3'b001:  return {{16{v[15]}}, v[15:0]};
      3'b101:  return v & 32'h0000_FFFF;
      default: return w;
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", {31'b0, stall}, {31'b0, e_stall});
      chk("bus_req", {31'b0, bus_req}, {31'b0, e_req});
      chk("misalign", {31'b0, misalign}, {31'b0, e_mis});
      chk("fault", {31'b0, fault}, {31'b0, e_fault});
      if (e_bus) begin
        chk("bus_we", {31'b0, bus_we}, {31'b0, e_we});
        chk("bus_addr", bus_addr, e_addr);
        chk("bus_be", {28'b0, bus_be}, {28'b0, e_be});
        chk("bus_wdata", bus_wdata, e_wd);
      end
      if (e_chk_rd) chk("rdata", rdata, e_rdata);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc();
    mem_rd = 0; mem_wr = 0; bus_ready = 0;
    e_stall = 0; e_req = 0; e_mis = 0; e_fault = 0; e_bus = 0; e_chk_rd = 1;
  endtask

  task automatic xfer(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input int waits, input logic [31:0] rdv, input logic to);
    int cycles;
    n_st = 0; n_req = 0;
    cyc();
    mem_rd = rd; mem_wr = wr; funct3 = f3; addr = a; wdata = wd; bus_ready = 0;
    e_fault = 0; e_bus = 0; e_req = 0; e_mis = m_mis(f3, a); e_stall = !m_mis(f3, a); e_chk_rd = 1;
    @(negedge clk);
    n_st += int'(stall); saw_mis = misalign; seen_req = bus_req;
    if (!m_mis(f3, a)) begin
      cycles = to ? TMO : waits + 1;
      for (int i = 0; i < cycles; i++) begin
        cyc();
        bus_ready = !to && i == cycles - 1;
        bus_rdata = bus_ready ? rdv : $urandom;
        e_stall = 1; e_req = 1; e_mis = 0; e_bus = 1; e_we = wr; e_chk_rd = 0;
        e_addr = {a[31:2], 2'b00}; e_be = m_be(f3, a); e_wd = m_wd(f3, wd);
        @(negedge clk);
        n_st += int'(stall); n_req += int'(bus_req);
        seen_be = bus_be; seen_wd = bus_wdata; seen_we = bus_we; seen_addr = bus_addr;
      end
      cyc();
      bus_ready = 0;
      e_stall = 0; e_req = 0; e_bus = 0; e_fault = to; e_chk_rd = 1;
      e_rdata = (to || wr) ? 32'h0 : m_load(f3, a, rdv);
      @(negedge clk);
      n_st += int'(stall); seen_rd = rdata; seen_fault = fault;
    end
    idle();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 0; mem_rd = 1; mem_wr = 0; funct3 = 3'b010; addr = 32'h40; wdata = 32'h0;
    bus_ready = 0; bus_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    e_stall = 0; e_req = 0; e_mis = 0; e_fault = 0; e_chk_rd = 1; e_rdata = 0;
    e_bus = 1; e_we = 0; e_addr = 0; e_be = 0; e_wd = 0;
    chk_en = 1;
    @(negedge clk);
    chk("reset_stall_forced", {31'b0, stall}, 32'h0);
    chk("reset_bus_be", {28'b0, bus_be}, 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    cyc();
    rst_n = 1; mem_rd = 0; e_bus = 0;
    @(negedge clk);

    xfer(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 32'h0, 0);
    chk("sw_addr", seen_addr, 32'h100);
    chk("sw_be", {28'b0, seen_be}, 32'hF);
    chk("sw_we", {31'b0, seen_we}, 32'h1);
    chk("sw_wdata", seen_wd, 32'hDEADBEEF);
    chk("sw_stall_cycles", n_st, 2);

    xfer(1, 0, 3'b000, 32'h103, 32'h0, 2, 32'h80FF_0000, 0);
    chk("lb_be", {28'b0, seen_be}, 32'h8);
    chk("lb_stall_cycles", n_st, 4);
    chk("lb_rdata", seen_rd, 32'hFFFFFF80);
    xfer(1, 0, 3'b100, 32'h103, 32'h0, 0, 32'h80FF_0000, 0);
    chk("lbu_rdata", seen_rd, 32'h00000080);

    xfer(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 1, 32'h0, 0);
    chk("sh_be", {28'b0, seen_be}, 32'hC);
    chk("sh_wdata", seen_wd, 32'hABCDABCD);
    chk("sh_rdata_zero", seen_rd, 32'h0);
    xfer(1, 0, 3'b010, 32'h202, 32'h0, 0, 32'h0, 0);
    chk("lw_mis_pulse", {31'b0, saw_mis}, 32'h1);
    chk("lw_mis_req", {31'b0, seen_req}, 32'h0);
    chk("lw_mis_stall", n_st, 0);
    xfer(1, 0, 3'b001, 32'h201, 32'h0, 0, 32'h0, 0);
    chk("lh_mis_pulse", {31'b0, saw_mis}, 32'h1);

    xfer(1, 0, 3'b001, 32'h202, 32'h0, 0, 32'h8001_7FFF, 0);
    chk("lh_hi", seen_rd, 32'hFFFF8001);
    xfer(1, 0, 3'b101, 32'h202, 32'h0, 1, 32'h8001_7FFF, 0);
    chk("lhu_hi", seen_rd, 32'h00008001);
    xfer(1, 0, 3'b001, 32'h200, 32'h0, 0, 32'h8001_7FFF, 0);
    chk("lh_lo", seen_rd, 32'h00007FFF);
    xfer(0, 1, 3'b000, 32'h101, 32'h000000A5, 0, 32'h0, 0);
    chk("sb_be", {28'b0, seen_be}, 32'h2);
    chk("sb_wdata", seen_wd, 32'hA5A5A5A5);
    xfer(1, 1, 3'b010, 32'h10, 32'h0BADF00D, 0, 32'h0, 0);
    chk("rdwr_we", {31'b0, seen_we}, 32'h1);
    xfer(1, 0, 3'b011, 32'h20, 32'h0, 0, 32'hCAFE0001, 0);
    chk("rsvd_be", {28'b0, seen_be}, 32'hF);
    xfer(1, 0, 3'b111, 32'h22, 32'h0, 0, 32'h0, 0);
    chk("rsvd_mis", {31'b0, saw_mis}, 32'h1);
    xfer(1, 0, 3'b010, 32'h10, 32'h0, 0, 32'h12345678, 0);
    chk("lw_rdata", seen_rd, 32'h12345678);

`ifdef LSU_TIMEOUT_EN
    xfer(1, 0, 3'b010, 32'h400, 32'h0, 0, 32'hAAAA5555, 1);
    chk("tmo_req_cycles", n_req, 4);
    chk("tmo_fault", {31'b0, seen_fault}, 32'h1);
    chk("tmo_rdata", seen_rd, 32'h0);
    xfer(1, 0, 3'b010, 32'h404, 32'h0, 3, 32'h5555AAAA, 0);
    chk("tmo_ready_wins", seen_rd, 32'h5555AAAA);
    chk("tmo_ready_fault", {31'b0, seen_fault}, 32'h0);
`else
    xfer(1, 0, 3'b010, 32'h400, 32'h0, 6, 32'hAAAA5555, 0);
    chk("long_wait_stall", n_st, 8);
    chk("long_wait_rdata", seen_rd, 32'hAAAA5555);
`endif

    cyc();
    mem_rd = 1; funct3 = 3'b010; addr = 32'h300; wdata = 32'h55;
    e_stall = 1; e_req = 0; e_mis = 0; e_fault = 0; e_bus = 0; e_chk_rd = 1;
    @(negedge clk);
    cyc();
    bus_ready = 0;
    e_req = 1; e_bus = 1; e_we = 0; e_addr = 32'h300; e_be = 4'hF; e_wd = 32'h55; e_chk_rd = 0;
    @(negedge clk);
    cyc();
    rst_n = 0;
    e_stall = 0;
    @(negedge clk);
    cyc();
    rst_n = 1; mem_rd = 0; bus_ready = 1; bus_rdata = 32'hFFFFFFFF;
    e_req = 0; e_stall = 0; e_bus = 1; e_we = 0; e_addr = 0; e_be = 0; e_wd = 0;
    e_rdata = 0; e_chk_rd = 1;
    @(negedge clk);
    chk("rst_mid_req", {31'b0, bus_req}, 32'h0);
    chk("rst_mid_rdata", rdata, 32'h0);
    cyc();
    e_bus = 0;
    @(negedge clk);
    idle();
    @(negedge clk);
    chk("late_ready_rdata", rdata, 32'h0);
    chk_en = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
